// File: rtl/flash_cmd_rx.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : flash_cmd_rx
// Parses flash program/erase command packets and feeds the ASMI writer Rx FIFO.
// Rev    : 1.0
// ---------------------------------------------------------------------------
module flash_cmd_rx #(
  parameter int FIFO_DEPTH = 1024,
  parameter int PAGE_BYTES = 256
) (
  input  logic        clock,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  input  logic        rx_last,
  input  logic [9:0]  fifo_wrusedw,
  output logic        fifo_wrreq,
  output logic [7:0]  fifo_data,
  output logic        erase,
  input  logic        erase_ACK,
  output logic [13:0] num_blocks,
  output logic        pkt_error,
  output logic [7:0]  drop_count
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_HDR   = 3'd1;
  localparam logic [2:0] S_CNT   = 3'd2;
  localparam logic [2:0] S_DATA  = 3'd3;
  localparam logic [2:0] S_PAD   = 3'd4;
  localparam logic [2:0] S_SKIP  = 3'd5;
  localparam logic [2:0] S_ERASE = 3'd6;

  localparam logic [10:0] SPACE_LIMIT = 11'(FIFO_DEPTH - PAGE_BYTES);
  localparam logic [8:0]  LAST_IDX    = 9'(PAGE_BYTES - 1);

  logic [2:0]  state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic [23:0] cnt_q, cnt_d;
  logic [8:0]  bcnt_q, bcnt_d;
  logic        wrreq_q, wrreq_d;
  logic [7:0]  data_q, data_d;
  logic        erase_q, erase_d;
  logic [13:0] nblk_q, nblk_d;
  logic        err_q, err_d;
  logic [7:0]  drop_q, drop_d;
  logic        last_q, last_d;

  logic [31:0] w_count;
  logic        w_last_seen;

  assign w_count     = {cnt_q, rx_data};
  assign w_last_seen = last_q | (rx_valid & rx_last);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    bcnt_d  = bcnt_q;
    wrreq_d = 1'b0;
    data_d  = data_q;
    erase_d = erase_q;
    nblk_d  = nblk_q;
    err_d   = 1'b0;
    drop_d  = drop_q;
    last_d  = last_q;

    case (state_q)
      S_IDLE: begin
        if (rx_valid) begin
          if (rx_data == 8'hEF && !rx_last) begin
            state_d = S_HDR;
            idx_d   = 2'd1;
          end else if (!rx_last) begin
            state_d = S_SKIP;
          end
        end
      end

      S_HDR: begin
        if (rx_valid) begin
          if (rx_last) begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end else begin
            case (idx_q)
              2'd1: begin
                if (rx_data != 8'hFE) begin
                  err_d   = 1'b1;
                  state_d = S_SKIP;
                end else begin
                  idx_d = 2'd2;
                end
              end
              2'd2: begin
                if (rx_data != 8'h03) begin
                  err_d   = 1'b1;
                  state_d = S_SKIP;
                end else begin
                  idx_d = 2'd3;
                end
              end
              default: begin
                if (rx_data == 8'h01) begin
                  state_d = S_CNT;
                  idx_d   = 2'd0;
                end else if (rx_data == 8'h02) begin
                  state_d = S_ERASE;
                  erase_d = 1'b1;
                  last_d  = 1'b0;
                end else begin
                  err_d   = 1'b1;
                  state_d = S_SKIP;
                end
              end
            endcase
          end
        end
      end

      S_CNT: begin
        if (rx_valid) begin
          if (rx_last) begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end else if (idx_q != 2'd3) begin
            cnt_d = {cnt_q[15:0], rx_data};
            idx_d = idx_q + 2'd1;
          end else if (w_count[31:14] != 18'd0 || w_count == 32'd0) begin
            err_d   = 1'b1;
            state_d = S_SKIP;
          end else begin
            // The image size is latched even when the page itself is dropped.
            nblk_d = w_count[13:0];
            if ({1'b0, fifo_wrusedw} <= SPACE_LIMIT) begin
              state_d = S_DATA;
              bcnt_d  = 9'd0;
            end else begin
              state_d = S_SKIP;
              if (drop_q != 8'hFF) drop_d = drop_q + 8'd1;
            end
          end
        end
      end

      S_DATA: begin
        if (rx_valid) begin
          wrreq_d = 1'b1;
          data_d  = rx_data;
          bcnt_d  = bcnt_q + 9'd1;
          if (bcnt_q == LAST_IDX) begin
            state_d = rx_last ? S_IDLE : S_SKIP;
          end else if (rx_last) begin
            state_d = S_PAD;
            err_d   = 1'b1;
          end
        end
      end

      S_PAD: begin
        // Fill the rest of the page so the FIFO stays page-aligned.
        wrreq_d = 1'b1;
        data_d  = 8'hFF;
        bcnt_d  = bcnt_q + 9'd1;
        if (bcnt_q == LAST_IDX) state_d = S_IDLE;
      end

      S_SKIP: begin
        if (rx_valid && rx_last) state_d = S_IDLE;
      end

      S_ERASE: begin
        last_d = w_last_seen;
        if (erase_ACK) begin
          erase_d = 1'b0;
          state_d = w_last_seen ? S_IDLE : S_SKIP;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= 2'd0;
      cnt_q   <= 24'd0;
      bcnt_q  <= 9'd0;
      wrreq_q <= 1'b0;
      data_q  <= 8'h00;
      erase_q <= 1'b0;
      nblk_q  <= 14'd0;
      err_q   <= 1'b0;
      drop_q  <= 8'd0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      bcnt_q  <= bcnt_d;
      wrreq_q <= wrreq_d;
      data_q  <= data_d;
      erase_q <= erase_d;
      nblk_q  <= nblk_d;
      err_q   <= err_d;
      drop_q  <= drop_d;
      last_q  <= last_d;
    end
  end

  assign fifo_wrreq = wrreq_q;
  assign fifo_data  = data_q;
  assign erase      = erase_q;
  assign num_blocks = nblk_q;
  assign pkt_error  = err_q;
  assign drop_count = drop_q;

endmodule
`default_nettype wire
